// File: rtl/fma_issue_ctrl_if.sv
// Request, datapath and response handshake bundle for the shared FMA issue controller.
interface fma_issue_ctrl_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned PARM_RM = 3
);
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         Req_valid_i;
  logic [NUM_REQ-1:0]         Req_ready_o;
  logic [NUM_REQ*PARM_RM-1:0] Req_rm_i;
  logic [NUM_REQ*TAG_W-1:0]   Req_tag_i;

  logic                       Dp_issue_o;
  logic [SEL_W-1:0]           Dp_sel_o;
  logic [PARM_RM-1:0]         Dp_rm_o;
  logic                       Dp_invalid_i;
  logic                       Dp_overflow_i;
  logic                       Dp_underflow_i;
  logic                       Dp_inexact_i;

  logic                       Rsp_valid_o;
  logic                       Rsp_ready_i;
  logic [SEL_W-1:0]           Rsp_id_o;
  logic [TAG_W-1:0]           Rsp_tag_o;
  logic [4:0]                 Rsp_flags_o;
  logic                       Rsp_illegal_o;

  modport master (
    output Req_valid_i, Req_rm_i, Req_tag_i,
    output Dp_invalid_i, Dp_overflow_i, Dp_underflow_i, Dp_inexact_i,
    output Rsp_ready_i,
    input  Req_ready_o, Dp_issue_o, Dp_sel_o, Dp_rm_o,
    input  Rsp_valid_o, Rsp_id_o, Rsp_tag_o, Rsp_flags_o, Rsp_illegal_o
  );

  modport slave (
    input  Req_valid_i, Req_rm_i, Req_tag_i,
    input  Dp_invalid_i, Dp_overflow_i, Dp_underflow_i, Dp_inexact_i,
    input  Rsp_ready_i,
    output Req_ready_o, Dp_issue_o, Dp_sel_o, Dp_rm_o,
    output Rsp_valid_o, Rsp_id_o, Rsp_tag_o, Rsp_flags_o, Rsp_illegal_o
  );
endinterface

// File: rtl/fma_issue_ctrl.sv
// Round-robin issue controller for the shared FMA datapath: rm resolution, shadow
// pipeline tracking, credit-protected response FIFO and sticky fflags accumulation.
module fma_issue_ctrl #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned PARM_RM    = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fma_issue_ctrl_if.slave     bus,
  input  logic                Frm_we_i,
  input  logic [2:0]          Frm_wdata_i,
  input  logic                Fflags_we_i,
  input  logic [4:0]          Fflags_wdata_i,
  output logic [2:0]          Frm_o,
  output logic [4:0]          Fflags_o,
  output logic                Busy_o
);

  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = SEL_W + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);

  typedef struct packed {
    logic [SEL_W-1:0] id;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } op_t;

  typedef struct packed {
    logic [SEL_W-1:0] id;
    logic [TAG_W-1:0] tag;
    logic [4:0]       flags;
    logic             illegal;
  } rsp_t;

  op_t                 sh_q   [PIPE_LAT];
  op_t                 sh_d   [PIPE_LAT];
  logic [PIPE_LAT-1:0] shv_q, shv_d;
  rsp_t                mem_q  [FIFO_DEPTH];
  rsp_t                mem_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    rr_q, rr_d;
  logic [2:0]          frm_q, frm_d;
  logic [4:0]          fflags_q, fflags_d;

  logic [CNT_W-1:0]     outstanding;
  logic                 pop, push, credit_ok, grant_vld, hs, illegal;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     k, grant_id;
  logic [SUM_W-1:0]     sum;
  logic [PARM_RM-1:0]   req_rm, rm_eff;
  logic [TAG_W-1:0]     req_tag;
  rsp_t                 push_ent;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover both the shadow pipeline and the FIFO; a same-cycle pop frees one.
  always_comb begin
    outstanding = cnt_q;
    for (int i = 0; i < int'(PIPE_LAT); i++) begin
      outstanding = outstanding + CNT_W'(shv_q[i]);
    end
    pop       = (cnt_q != '0) && bus.Rsp_ready_i;
    credit_ok = (outstanding < CNT_W'(FIFO_DEPTH)) || pop;
  end

  // Rotate valids by the RR pointer, pick the lowest, then rotate the index back.
  always_comb begin
    dbl       = {bus.Req_valid_i, bus.Req_valid_i};
    rot       = NUM_REQ'(dbl >> rr_q);
    grant_vld = |rot;
    k         = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) k = SEL_W'(i);
    end
    sum      = {1'b0, rr_q} + {1'b0, k};
    grant_id = (sum >= SUM_W'(NUM_REQ)) ? SEL_W'(sum - SUM_W'(NUM_REQ)) : SEL_W'(sum);
    hs       = grant_vld && credit_ok;
  end

  always_comb begin
    req_rm  = '0;
    req_tag = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_id == SEL_W'(i)) begin
        req_rm  = bus.Req_rm_i[i*PARM_RM +: PARM_RM];
        req_tag = bus.Req_tag_i[i*TAG_W +: TAG_W];
      end
    end
    rm_eff  = (req_rm == '1) ? PARM_RM'(frm_q) : req_rm;
    illegal = (rm_eff >= PARM_RM'(5));
  end

  assign bus.Req_ready_o = hs ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.Dp_issue_o  = hs && !illegal;
  assign bus.Dp_sel_o    = (hs && !illegal) ? grant_id : '0;
  assign bus.Dp_rm_o     = (hs && !illegal) ? rm_eff : '0;

  // Shadow pipeline; the last stage lines up with the datapath flags.
  always_comb begin
    shv_d    = {shv_q[PIPE_LAT-2 >= 0 ? PIPE_LAT-2 : 0 : 0], hs};
    sh_d[0]  = '{id: grant_id, tag: req_tag, illegal: illegal};
    for (int i = 1; i < int'(PIPE_LAT); i++) begin
      sh_d[i] = sh_q[i-1];
    end
    push           = shv_q[PIPE_LAT-1];
    push_ent.id    = sh_q[PIPE_LAT-1].id;
    push_ent.tag   = sh_q[PIPE_LAT-1].tag;
    push_ent.illegal = sh_q[PIPE_LAT-1].illegal;
    push_ent.flags = sh_q[PIPE_LAT-1].illegal ? 5'b0 :
                     {bus.Dp_invalid_i, 1'b0, bus.Dp_overflow_i, bus.Dp_underflow_i, bus.Dp_inexact_i};
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = push_ent;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) rd_d = ptr_inc(rd_q);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // A CSR write coinciding with a push must not drop the new exception bits.
  always_comb begin
    frm_d    = Frm_we_i ? Frm_wdata_i : frm_q;
    fflags_d = Fflags_we_i ? Fflags_wdata_i : fflags_q;
    if (push && !push_ent.illegal) fflags_d = fflags_d | push_ent.flags;
    rr_d     = rr_q;
    if (hs) rr_d = (grant_id == SEL_W'(NUM_REQ - 1)) ? '0 : grant_id + SEL_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frm_q    <= '0;
      fflags_q <= '0;
      rr_q     <= '0;
      shv_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) sh_q[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      frm_q    <= frm_d;
      fflags_q <= fflags_d;
      rr_q     <= rr_d;
      shv_q    <= shv_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.Rsp_valid_o   = (cnt_q != '0);
  assign bus.Rsp_id_o      = mem_q[rd_q].id;
  assign bus.Rsp_tag_o     = mem_q[rd_q].tag;
  assign bus.Rsp_flags_o   = mem_q[rd_q].flags;
  assign bus.Rsp_illegal_o = mem_q[rd_q].illegal;
  assign Frm_o             = frm_q;
  assign Fflags_o          = fflags_q;
  assign Busy_o            = (|shv_q) || (cnt_q != '0);

endmodule
